// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants and types for the 1-to-4 stream demux.
//               N_CH  - number of output channels
//               SEL_W - width of the channel select
//               CNT_W - width of each per-channel accepted-word counter
//               sel_t - channel select type
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;
endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_slot
// Description : One-entry register stage for a single demux output channel.
// Ports       : clk, rst_n  - clock, asynchronous active-low reset
//               load        - write data_in into the slot this edge
//               data_in     - word to store
//               ready       - consumer accepts the held word this edge
//               valid       - slot holds an undelivered word
//               data        - held word (keeps last value after draining)
// Revision    : 1.0 - initial release
// ============================================================================
module demux_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] data_in,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data
);

  // A load has priority over a drain so a simultaneous drain/load keeps
  // valid high with the new word and leaves no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux1x4_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux1x4_stream
// Description : Registered 1-to-4 stream demultiplexer. Each input word is
//               steered by in_sel into one of four one-entry channel slots,
//               each with its own valid/ready handshake. A stalled channel
//               only blocks words addressed to it.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               in_data/in_sel      - input word and destination channel
//               in_valid/in_ready   - input handshake
//               out_data            - channel k in [k*DW +: DW]
//               out_valid/out_ready - per-channel output handshake
//               acc_cnt             - per-channel accepted-word counters,
//                                     channel k in [k*8 +: 8]
// Config      : DEMUX1X4_STREAM_CNT_EN - when defined, acc_cnt counts input
//               transfers per channel (8-bit, wrapping); otherwise it is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module demux1x4_stream
  import demux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DW-1:0]         in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_CH*DW-1:0]    out_data,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [N_CH*CNT_W-1:0] acc_cnt
);

  sel_t            sel;
  logic [N_CH-1:0] load;

  assign sel = in_sel;

  // Ready depends only on the addressed channel, never on in_valid, so a
  // source that redirects in_sel sees the new channel's state immediately.
  assign in_ready = ~out_valid[sel] | out_ready[sel];

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_slot
      assign load[k] = in_valid && in_ready && (sel == sel_t'(k));

      demux_slot #(
        .DW (DW)
      ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load[k]),
        .data_in (in_data),
        .ready   (out_ready[k]),
        .valid   (out_valid[k]),
        .data    (out_data[k*DW +: DW])
      );
    end
  endgenerate

`ifdef DEMUX1X4_STREAM_CNT_EN
  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_cnt
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (load[k]) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign acc_cnt[k*CNT_W +: CNT_W] = cnt;
    end
  endgenerate
`else
  assign acc_cnt = '0;
`endif

endmodule
`default_nettype wire
